// File: rtl/alu_arbiter32.sv
// Two-port arbiter in front of a shared combinational 32-bit ALU.
// Accepts one operation at a time, runs it through the ALU for one cycle, and holds the response until consumed.
module alu_arbiter32 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_rs1,
    input  logic [63:0] req_rs2,
    input  logic [7:0]  req_ctrl,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic        id_q, id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;
    logic        rsp_id_q, rsp_id_d;
    logic        rsp_err_q, rsp_err_d;
    logic        grant;
    logic        ctrl_illegal;

    always_comb begin
        if (req_valid == 2'b11) begin
            grant = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end else begin
            grant = req_valid[1];
        end
    end

    // rst_n gates the handshake so ready drops immediately while reset is held.
    always_comb begin
        req_ready = 2'b00;
        if (state_q == S_IDLE && rst_n) begin
            req_ready[grant] = req_valid[grant];
        end
    end

    assign ctrl_illegal = (ctrl_q[3:2] == 2'b11);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        ctrl_d       = ctrl_q;
        id_d         = id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    rs1_d        = grant ? req_rs1[63:32] : req_rs1[31:0];
                    rs2_d        = grant ? req_rs2[63:32] : req_rs2[31:0];
                    ctrl_d       = grant ? req_ctrl[7:4]  : req_ctrl[3:0];
                    id_d         = grant;
                    last_grant_d = grant;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_result_d = ctrl_illegal ? 32'd0 : alu_result;
                rsp_flags_d  = ctrl_illegal ? 4'd0  : alu_flags;
                rsp_err_d    = ctrl_illegal;
                rsp_id_d     = id_q;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            rs1_q        <= '0;
            rs2_q        <= '0;
            ctrl_q       <= '0;
            id_q         <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            ctrl_q       <= ctrl_d;
            id_q         <= id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_rs1    = rs1_q;
    assign alu_rs2    = rs2_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter32.sv
// Bench for alu_arbiter32: round-robin and fixed-priority instances share stimulus;
// expectations come from a grant/ALU reference model kept here.
module tb_alu_arbiter32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [63:0] req_rs1, req_rs2;
    logic [7:0]  req_ctrl;
    logic        rsp_ready;

    logic [1:0]  req_ready, req_ready_f;
    logic [31:0] alu_rs1, alu_rs2, alu_rs1_f, alu_rs2_f;
    logic [3:0]  alu_ctrl, alu_ctrl_f;
    logic [31:0] alu_result, alu_result_f;
    logic [3:0]  alu_flags, alu_flags_f;
    logic        rsp_valid, rsp_valid_f, rsp_id, rsp_id_f, rsp_err, rsp_err_f, busy, busy_f;
    logic [31:0] rsp_result, rsp_result_f;
    logic [3:0]  rsp_flags, rsp_flags_f;

    int checks = 0;
    int errors = 0;
    logic last_grant;

    always #5 clk = ~clk;

    // Reference ALU: {overflow, carry, negative, zero, result}; illegal opcodes return junk.
    function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        w = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = $signed(a) >>> b[4:0];
            4'd8: r = {31'd0, $signed(a) < $signed(b)};
            4'd9: r = {31'd0, a < b};
            4'd10: r = a;
            4'd11: r = b;
            default: return {4'hF, 32'hDEADBEEF};
        endcase
        return {v, c, r[31], (r == 32'd0), r};
    endfunction

    function automatic logic [35:0] exp_rsp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        if (op >= 4'd12) return 36'd0;
        return alu_f(a, b, op);
    endfunction

    assign {alu_flags, alu_result}     = alu_f(alu_rs1, alu_rs2, alu_ctrl);
    assign {alu_flags_f, alu_result_f} = alu_f(alu_rs1_f, alu_rs2_f, alu_ctrl_f);

    alu_arbiter32 #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_ctrl(req_ctrl),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
    );

    alu_arbiter32 #(.FIXED_PRIO(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_f),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_ctrl(req_ctrl),
        .alu_rs1(alu_rs1_f), .alu_rs2(alu_rs2_f), .alu_ctrl(alu_ctrl_f),
        .alu_result(alu_result_f), .alu_flags(alu_flags_f),
        .rsp_valid(rsp_valid_f), .rsp_ready(rsp_ready), .rsp_id(rsp_id_f),
        .rsp_result(rsp_result_f), .rsp_flags(rsp_flags_f), .rsp_err(rsp_err_f), .busy(busy_f)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        check({tag, " busy"}, 64'(busy), 64'(1'b0));
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(1'b0));
        check({tag, " req_ready"}, 64'(req_ready), 64'(2'b00));
        check({tag, " req_ready_f"}, 64'(req_ready_f), 64'(2'b00));
        check({tag, " rsp_result"}, 64'(rsp_result), 64'd0);
        check({tag, " rsp_id/err"}, 64'({rsp_id, rsp_err}), 64'(2'b00));
        check({tag, " alu_rs1"}, 64'(alu_rs1), 64'd0);
        check({tag, " busy_f"}, 64'(busy_f), 64'(1'b0));
    endtask

    // One full transaction; inputs change 1 time unit after a rising edge.
    task automatic do_op(input logic [1:0] v,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                         input int hold);
        logic        g, gf;
        logic [35:0] e, ef;
        logic        ee, eef;
        req_valid = v;
        req_rs1   = {a1, a0};
        req_rs2   = {b1, b0};
        req_ctrl  = {c1, c0};
        g  = (v == 2'b11) ? ~last_grant : v[1];
        gf = (v == 2'b11) ? 1'b0 : v[1];
        #1;
        check("idle ready rr", 64'(req_ready), 64'((v == 2'b00) ? 2'b00 : (2'b01 << g)));
        check("idle ready fp", 64'(req_ready_f), 64'((v == 2'b00) ? 2'b00 : (2'b01 << gf)));
        if (v == 2'b00) begin
            @(posedge clk); #1;
            check("no req busy", 64'({busy, busy_f}), 64'(2'b00));
            return;
        end
        e   = g  ? exp_rsp(a1, b1, c1) : exp_rsp(a0, b0, c0);
        ee  = g  ? (c1 >= 4'd12) : (c0 >= 4'd12);
        ef  = gf ? exp_rsp(a1, b1, c1) : exp_rsp(a0, b0, c0);
        eef = gf ? (c1 >= 4'd12) : (c0 >= 4'd12);
        @(posedge clk); #1;
        last_grant = g;
        check("exec busy/valid", 64'({busy, rsp_valid}), 64'(2'b10));
        check("exec ready", 64'({req_ready, req_ready_f}), 64'(4'b0000));
        check("exec alu_rs1", 64'(alu_rs1), 64'(g ? a1 : a0));
        check("exec alu_ctrl", 64'(alu_ctrl), 64'(g ? c1 : c0));
        @(posedge clk); #1;
        check("resp valid", 64'({rsp_valid, rsp_valid_f}), 64'(2'b11));
        check("resp rr", 64'({rsp_id, rsp_err, rsp_flags, rsp_result}), 64'({g, ee, e}));
        check("resp fp", 64'({rsp_id_f, rsp_err_f, rsp_flags_f, rsp_result_f}), 64'({gf, eef, ef}));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold stable", 64'({rsp_valid, busy, req_ready, rsp_id, rsp_err, rsp_flags, rsp_result}),
                  64'({2'b11, 2'b00, g, ee, e}));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("after hs", 64'({rsp_valid, busy, rsp_valid_f, busy_f}), 64'(4'b0000));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_rs1   = '0;
        req_rs2   = '0;
        req_ctrl  = '0;
        rsp_ready = 1'b0;
        last_grant = 1'b1;
        #12;
        chk_reset_outputs("reset");
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_op(2'b01, 32'd5, 32'd3, 4'd0, 32'd0, 32'd0, 4'd0, 0);
        check("add 5+3", 64'({rsp_flags, rsp_result}), 64'({4'd0, 32'd8}));

        for (int i = 0; i < 4; i++)
            do_op(2'b11, 32'd100 + i, 32'd7, 4'd1, 32'd200 + i, 32'd9, 4'd0, 0);

        do_op(2'b10, 32'd0, 32'd0, 4'd0, 32'hFFFF_FFFF, 32'd1, 4'd0, 5);
        do_op(2'b10, 32'd1, 32'd2, 4'd0, 32'h1234_5678, 32'h9ABC, 4'b1110, 0);
        check("illegal op", 64'({rsp_err, rsp_id, rsp_flags, rsp_result}), 64'({1'b1, 1'b1, 36'd0}));
        do_op(2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 0);

        for (int i = 0; i < 40; i++)
            do_op(2'($urandom_range(1, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                  $urandom, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

        req_valid = 2'b11;
        req_rs1   = {32'd9, 32'd8};
        @(posedge clk); #1;
        check("pre-reset exec", 64'(busy), 64'(1'b1));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset in exec");
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post-reset quiet", 64'({rsp_valid, busy, rsp_valid_f, busy_f}), 64'(4'b0000));
        end
        do_op(2'b11, 32'd11, 32'd22, 4'd0, 32'd33, 32'd44, 4'd3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
